// File: rtl/dsp_pkg.sv
// dsp_pkg: shared demod sample type, block state encoding and arithmetic helpers
package dsp_pkg;
    localparam int SAMPLE_W = 16;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef enum logic {ST_CLEAR, ST_RUN} dcr_state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w,
                                                   output logic clip);
        logic signed [31:0] s, hi, lo;
        s = a + b;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        clip = (s > hi) || (s < lo);
        return (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction
endpackage

// File: rtl/ring_buf_1r1w.sv
// ring_buf_1r1w: sample store with one synchronous write port and one asynchronous read port
module ring_buf_1r1w #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 16,
    parameter int AW = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/dc_restore_128.sv
// dc_restore_128: adds the running mean of a reference stream back onto a zero-mean data stream
module dc_restore_128
    import dsp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SAMPLES = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    strobe_i,
    input  logic signed [WIDTH-1:0] data_i,
    input  logic signed [WIDTH-1:0] level_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic signed [WIDTH-1:0] data_o,
    output logic signed [WIDTH-1:0] mean_o,
    output logic                    sat_o,
    output logic                    primed_o
);
    localparam int ADDR = clog2(SAMPLES);
    localparam int SUMW = WIDTH + ADDR;
    dcr_state_t state, state_n;
    logic [ADDR-1:0] clr_ptr, wr_ptr, wa;
    logic [ADDR:0] fill_cnt;
    logic signed [SUMW-1:0] sum;
    logic signed [WIDTH-1:0] data_r, level_r, data_r2, old, mean, data_sat, wd;
    logic v1, v2, accept, we, add_sat;
    always_ff @(posedge clk) begin
        if (rst) state <= ST_CLEAR;
        else state <= state_n;
    end
    always_comb begin
        state_n = clear_i ? ST_CLEAR : (state == ST_CLEAR && &clr_ptr) ? ST_RUN : state;
    end
    assign ready_o = (state == ST_RUN);
    assign accept = strobe_i & ready_o & ~clear_i;
    // The clear walk and the running write share the single write port.
    assign we = (state == ST_CLEAR) | v1;
    assign wa = (state == ST_CLEAR) ? clr_ptr : wr_ptr;
    assign wd = (state == ST_CLEAR) ? '0 : level_r;
    ring_buf_1r1w #(.DEPTH(SAMPLES), .WIDTH(WIDTH), .AW(ADDR)) u_buf (
        .clk    (clk),
        .we     (we),
        .wr_addr(wa),
        .wr_data(wd),
        .rd_addr(wr_ptr),
        .rd_data(old)
    );
    assign mean = WIDTH'(sum >>> ADDR);
    always_comb begin
        add_sat = 1'b0;
        data_sat = WIDTH'(sat_add(32'(data_r2), 32'(mean), WIDTH, add_sat));
    end
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            clr_ptr <= '0;
            wr_ptr <= '0;
            fill_cnt <= '0;
            sum <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            valid_o <= 1'b0;
            primed_o <= 1'b0;
            if (rst) begin
                data_o <= '0;
                mean_o <= '0;
                sat_o <= 1'b0;
            end
        end else begin
            clr_ptr <= (state == ST_CLEAR) ? clr_ptr + 1'b1 : '0;
            v1 <= accept;
            v2 <= v1;
            valid_o <= v2;
            primed_o <= fill_cnt[ADDR];
            if (accept) begin
                data_r <= data_i;
                level_r <= level_i;
            end
            if (v1) begin
                wr_ptr <= wr_ptr + 1'b1;
                sum <= sum + SUMW'(level_r) - SUMW'(old);
                fill_cnt <= fill_cnt + {{ADDR{1'b0}}, ~fill_cnt[ADDR]};
                data_r2 <= data_r;
            end
            if (v2) begin
                data_o <= data_sat;
                mean_o <= mean;
                sat_o <= add_sat;
            end
        end
    end
endmodule
